// File: rtl/ula_pkg.sv
// Shared definitions for the ULA issue path: default widths, op_sel codes
// understood by the 4-bit ULA, and the issue controller state encoding.
package ula_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int SEL_W_DEF  = 4;

  // Logic class (01xx) and arithmetic classes (10xx add, 11xx subtract).
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NAND = 4'b0111;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } ula_state_t;

endpackage

// File: rtl/ula_wdog.sv
// Watchdog for the ULA acknowledge wait. Counts enabled cycles since the
// last clear; 'expired' is high on the enabled cycle whose count would
// reach TIMEOUT, so the owner can act on the same edge.
module ula_wdog #(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  assign expired = en && (count == LAST);

  // Count enabled cycles; clear has priority, and the count stops at LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ula_ctrl.sv
// Issue controller in front of the 4-bit ULA.
// Handshake: a request is accepted when start=1 is sampled in IDLE; the ULA
// sees ula_ena=1 for exactly one cycle, and the operation completes on the
// first edge in WAIT with ula_ack=1 (done pulse) or when the watchdog
// expires (done and err pulses). start while busy is dropped (req_drop).
// Optional feature macro: ULA_CTRL_ACCUM_EN (use_acc selects the last
// non-error result as op1).
module ula_ctrl
  import ula_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [SEL_W-1:0]  op_code,
  input  logic              use_acc,
  output logic              ula_ena,
  output logic [DATA_W-1:0] ula_op1,
  output logic [DATA_W-1:0] ula_op2,
  output logic [SEL_W-1:0]  ula_op_sel,
  input  logic [DATA_W-1:0] ula_res,
  input  logic              ula_ack,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic              req_drop
);

  ula_state_t        state;
  logic              wd_expired;
  logic [DATA_W-1:0] op1_src;

  // Watchdog is cleared while issuing and counts WAIT cycles without ack.
  ula_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state == ISSUE),
    .en      ((state == WAIT) && !ula_ack),
    .expired (wd_expired)
  );

`ifdef ULA_CTRL_ACCUM_EN
  logic [DATA_W-1:0] acc;

  // Accumulator follows every successful result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if ((state == WAIT) && ula_ack) begin
      acc <= ula_res;
    end
  end

  assign op1_src = use_acc ? acc : op_a;
`else
  logic unused_use_acc;
  assign unused_use_acc = use_acc;
  assign op1_src        = op_a;
`endif

  // Issue FSM with registered outputs; done/err/req_drop default to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ula_ena    <= 1'b0;
      ula_op1    <= '0;
      ula_op2    <= '0;
      ula_op_sel <= '0;
      result     <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      req_drop   <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      req_drop <= 1'b0;
      if ((state != IDLE) && start) begin
        req_drop <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            ula_op1    <= op1_src;
            ula_op2    <= op_b;
            ula_op_sel <= op_code;
            ula_ena    <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          ula_ena <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          if (ula_ack) begin
            result <= ula_res;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (wd_expired) begin
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
